// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the AVR external-SRAM window controller.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        SLOT_IDE  = 2'd0,
        SLOT_SD   = 2'd1,
        SLOT_CDDA = 2'd2
    } slot_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    localparam logic [15:0] SRAM_BASE  = 16'hE000;
    localparam logic [7:0]  ABORT_DATA = 8'hFF;

    // Window offset bits 11:10 pick the slave; CDDA owns the whole upper 2 KiB.
    function automatic slot_e slot_decode(input logic [1:0] a_hi);
        if (a_hi[1])
            return SLOT_CDDA;
        else if (a_hi[0])
            return SLOT_SD;
        else
            return SLOT_IDE;
    endfunction

endpackage

// File: rtl/bus_irq_sync.sv
// Shift-chain synchroniser whose stages advance only when en is high.
module bus_irq_sync
    import sram_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else if (en) begin
            chain[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                chain[i] <= chain[i-1];
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/sram_bus_controller.sv
// Sequences CPU accesses in the external-SRAM window onto the IDE, SD-card and
// CDDA slaves; also derives the CPU clock/phase and guards against stuck waits.
module sram_bus_controller
    import sram_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int IRQ_FLOPS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        clkout_cpu,
    output logic [1:0]  phase,
    input  logic [15:0] sram_a,
    input  logic        sram_cs,
    input  logic        sram_oe,
    input  logic        sram_we,
    output logic [7:0]  cpu_d_in,
    output logic        cpu_wait,
    output logic        cs_ide,
    output logic        cs_sdcard,
    output logic        cs_cdda,
    input  logic [7:0]  d_ide,
    input  logic [7:0]  d_sdcard,
    input  logic [7:0]  d_cdda,
    input  logic        wait_ide,
    input  logic        wait_sdcard,
    input  logic        wait_cdda,
    input  logic        irq_ide,
    output logic        cpu_irq,
    output logic        bus_err,
    input  logic        bus_err_clr
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic        err_set;
    logic        abort;
    logic        phase0;
    slot_e       slot;
    logic        slave_wait;
    logic [7:0]  slave_data;

    // Only the slot bits are decoded; the CPU core already qualifies the
    // window with sram_cs, and direction does not affect select timing.
    logic        sig_unused;
    assign sig_unused = ^{sram_a[15:12] ^ SRAM_BASE[15:12], sram_a[9:0], sram_oe, sram_we};

    // CPU clock: low for phases 0,1 and high for phases 2,3.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= 2'd0;
            clkout_cpu <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (phase[0])
                clkout_cpu <= ~clkout_cpu;
        end
    end

    assign phase0 = (phase == 2'd0);
    assign slot   = slot_decode(sram_a[11:10]);
    assign abort  = (state == ABORT);

    always_comb begin
        slave_wait = wait_ide;
        slave_data = d_ide;
        case (slot)
            SLOT_SD: begin
                slave_wait = wait_sdcard;
                slave_data = d_sdcard;
            end
            SLOT_CDDA: begin
                slave_wait = wait_cdda;
                slave_data = d_cdda;
            end
            default: begin
                slave_wait = wait_ide;
                slave_data = d_ide;
            end
        endcase
    end

    // Fast slaves only see a one-clk select in the phase-0 window; CDDA is
    // slow enough to take the select for the whole access.
    assign cs_ide    = sram_cs & (slot == SLOT_IDE)  & phase0 & ~abort;
    assign cs_sdcard = sram_cs & (slot == SLOT_SD)   & phase0 & ~abort;
    assign cs_cdda   = sram_cs & (slot == SLOT_CDDA) & ~abort;

    assign cpu_d_in = abort ? ABORT_DATA : slave_data;
    assign cpu_wait = sram_cs & slave_wait & ~abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bus_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (err_set)
                bus_err <= 1'b1;
            else if (bus_err_clr)
                bus_err <= 1'b0;
        end
    end

    // DONE and ABORT only leave on ~sram_cs so a held strobe with a new
    // address is never treated as a second access.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (sram_cs && slave_wait) begin
                    state_next = BUSY;
                    cnt_next   = 16'd1;
                end
            end
            BUSY: begin
                if (!sram_cs) begin
                    state_next = IDLE;
                end else if (!slave_wait) begin
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ABORT;
                    err_set    = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            DONE: begin
                if (!sram_cs)
                    state_next = IDLE;
            end
            ABORT: begin
                if (!sram_cs)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    bus_irq_sync #(
        .DEPTH (IRQ_FLOPS)
    ) u_irq_sync (
        .clk (clk),
        .rst (rst),
        .en  (phase0),
        .d   (irq_ide),
        .q   (cpu_irq)
    );

endmodule

// File: tb/tb_sram_bus_controller.sv
// Directed self-checking bench for sram_bus_controller (TIMEOUT_CYC=16, IRQ_FLOPS=2).
module tb_sram_bus_controller;
    import sram_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkout_cpu;
    logic [1:0]  phase;
    logic [15:0] sram_a;
    logic        sram_cs, sram_oe, sram_we;
    logic [7:0]  cpu_d_in;
    logic        cpu_wait;
    logic        cs_ide, cs_sdcard, cs_cdda;
    logic [7:0]  d_ide, d_sdcard, d_cdda;
    logic        wait_ide, wait_sdcard, wait_cdda;
    logic        irq_ide;
    logic        cpu_irq;
    logic        bus_err;
    logic        bus_err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bus_controller #(
        .TIMEOUT_CYC (16),
        .IRQ_FLOPS   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clkout_cpu  (clkout_cpu),
        .phase       (phase),
        .sram_a      (sram_a),
        .sram_cs     (sram_cs),
        .sram_oe     (sram_oe),
        .sram_we     (sram_we),
        .cpu_d_in    (cpu_d_in),
        .cpu_wait    (cpu_wait),
        .cs_ide      (cs_ide),
        .cs_sdcard   (cs_sdcard),
        .cs_cdda     (cs_cdda),
        .d_ide       (d_ide),
        .d_sdcard    (d_sdcard),
        .d_cdda      (d_cdda),
        .wait_ide    (wait_ide),
        .wait_sdcard (wait_sdcard),
        .wait_cdda   (wait_cdda),
        .irq_ide     (irq_ide),
        .cpu_irq     (cpu_irq),
        .bus_err     (bus_err),
        .bus_err_clr (bus_err_clr)
    );

    // Bounded search for a negedge at which the DUT sits in phase p.
    task automatic align(input logic [1:0] p);
        int n;
        n = 0;
        @(negedge clk);
        while (phase !== p && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase !== p) begin
            errors++;
            $display("FAIL align: phase=%0d want %0d", phase, p);
        end
    endtask

    task automatic bus_idle();
        sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0; sram_a = 16'hE000;
        wait_ide = 1'b0; wait_sdcard = 1'b0; wait_cdda = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] ep;
        rst = 1'b1;
        bus_idle();
        d_ide = 8'h00; d_sdcard = 8'h00; d_cdda = 8'h00;
        irq_ide = 1'b0; bus_err_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (phase !== 2'd0 || clkout_cpu !== 1'b0 || cpu_irq !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: phase=%0d clk=%b irq=%b err=%b want 0 0 0 0",
                     phase, clkout_cpu, cpu_irq, bus_err);
        end
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            ep = 2'(i % 4);
            checks++;
            if (phase !== ep || clkout_cpu !== ep[1]) begin
                errors++;
                $display("FAIL clkgen[%0d]: phase=%0d clk=%b want %0d %b", i, phase, clkout_cpu, ep, ep[1]);
            end
        end
        checks++;
        if (cpu_irq !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_flags: irq=%b err=%b want 0 0", cpu_irq, bus_err);
        end
    endtask

    task automatic test_ide_read();
        align(2'd0);
        sram_a = 16'hE000; sram_cs = 1'b1; sram_oe = 1'b1;
        d_ide = 8'h5A; d_sdcard = 8'h33; d_cdda = 8'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (cs_ide !== (k == 0) || cs_sdcard !== 1'b0 || cs_cdda !== 1'b0) begin
                errors++;
                $display("FAIL ide_cs[%0d]: ide=%b sd=%b cdda=%b want %b 0 0", k, cs_ide, cs_sdcard, cs_cdda, (k == 0));
            end
            checks++;
            if (cpu_d_in !== 8'h5A || cpu_wait !== 1'b0) begin
                errors++;
                $display("FAIL ide_data[%0d]: d=%h wait=%b want 5a 0", k, cpu_d_in, cpu_wait);
            end
            @(negedge clk);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_cdda_wait();
        align(2'd0);
        sram_a = 16'hE800; sram_cs = 1'b1; sram_oe = 1'b1;
        wait_cdda = 1'b1; d_cdda = 8'hC3;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (cpu_wait !== 1'b1 || cs_cdda !== 1'b1 || cs_ide !== 1'b0) begin
                errors++;
                $display("FAIL cdda_wait[%0d]: wait=%b cdda=%b ide=%b want 1 1 0", k, cpu_wait, cs_cdda, cs_ide);
            end
            @(negedge clk);
        end
        wait_cdda = 1'b0;
        #1;
        checks++;
        if (cpu_wait !== 1'b0 || cpu_d_in !== 8'hC3 || cs_cdda !== 1'b1) begin
            errors++;
            $display("FAIL cdda_release: wait=%b d=%h cdda=%b want 0 c3 1", cpu_wait, cpu_d_in, cs_cdda);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== DONE || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL cdda_done: state=%0d err=%b want %0d 0", dut.state, bus_err, DONE);
        end
        bus_idle();
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL cdda_idle: state=%0d want %0d", dut.state, IDLE);
        end
    endtask

    // Starts an SD write with a stuck wait and checks the first 15 clks of wait.
    task automatic sd_stuck_prefix(input string tag);
        align(2'd0);
        sram_a = 16'hE400; sram_cs = 1'b1; sram_we = 1'b1;
        wait_sdcard = 1'b1; d_sdcard = 8'h11;
        for (int k = 0; k < 15; k++) begin
            #1;
            checks++;
            if (cpu_wait !== 1'b1 || cs_sdcard !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL %s_wait[%0d]: wait=%b sd=%b want 1 %b", tag, k, cpu_wait, cs_sdcard, (k % 4 == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        sd_stuck_prefix("to");
        #1;
        checks++;
        if (cpu_wait !== 1'b1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL to_last: wait=%b err=%b want 1 0", cpu_wait, bus_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cpu_wait !== 1'b0 || cs_sdcard !== 1'b0 || cpu_d_in !== 8'hFF || bus_err !== 1'b1 || phase !== 2'd0) begin
            errors++;
            $display("FAIL to_abort: wait=%b sd=%b d=%h err=%b ph=%0d want 0 0 ff 1 0",
                     cpu_wait, cs_sdcard, cpu_d_in, bus_err, phase);
        end
        bus_idle();
        @(negedge clk);
        bus_err_clr = 1'b1;
        @(negedge clk);
        bus_err_clr = 1'b0;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b want 0", bus_err);
        end
        sd_stuck_prefix("to2");
        bus_err_clr = 1'b1;
        @(negedge clk);
        bus_err_clr = 1'b0;
        checks++;
        if (bus_err !== 1'b1 || dut.state !== ABORT) begin
            errors++;
            $display("FAIL err_set_wins: err=%b state=%0d want 1 %0d", bus_err, dut.state, ABORT);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_irq();
        align(2'd2);
        irq_ide = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (cpu_irq !== (n >= 7)) begin
                errors++;
                $display("FAIL irq_rise[%0d]: irq=%b want %b", n, cpu_irq, (n >= 7));
            end
        end
        irq_ide = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++;
            if (cpu_irq !== (n < 7)) begin
                errors++;
                $display("FAIL irq_fall[%0d]: irq=%b want %b", n, cpu_irq, (n < 7));
            end
        end
    endtask

    task automatic test_reset_mid_access();
        align(2'd0);
        sram_a = 16'hE000; sram_cs = 1'b1; sram_oe = 1'b1; wait_ide = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (dut.state !== BUSY || dut.cnt !== 16'd10) begin
            errors++;
            $display("FAIL mid_busy: state=%0d cnt=%0d want %0d 10", dut.state, dut.cnt, BUSY);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (dut.state !== IDLE || dut.cnt !== 16'd0 || phase !== 2'd0 || bus_err !== 1'b0 || cpu_wait !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: state=%0d cnt=%0d ph=%0d err=%b wait=%b want %0d 0 0 0 1",
                     dut.state, dut.cnt, phase, bus_err, cpu_wait, IDLE);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (cpu_wait !== 1'b1) begin
                errors++;
                $display("FAIL retry_wait[%0d]: wait=%b want 1", k, cpu_wait);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (cpu_wait !== 1'b0 || bus_err !== 1'b1 || cpu_d_in !== 8'hFF) begin
            errors++;
            $display("FAIL retry_abort: wait=%b err=%b d=%h want 0 1 ff", cpu_wait, bus_err, cpu_d_in);
        end
        bus_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ide_read();
        test_cdda_wait();
        test_timeout();
        test_irq();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit reached", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
